instruction_fetch: RTL
======================

// Module: instruction_fetch
// PURPOSE
//   IF stage plus IF/ID pipeline register, directly upstream of the ID stage feeding id_ex.
//   Owns the program counter, drives instruction-memory address, latches fetched word and PC+1
//   into IF/ID. Handles stall (hold), branch redirect/flush from EX, and HLT via a 2-state FSM.
// PARAMETERS
//   RESET_PC      16'h0000   PC value loaded on reset
//   HALT_PATTERN  16'hC0F0   instruction bits identifying HLT (after masking)
//   HALT_MASK     16'hC0F0   bits compared against HALT_PATTERN
// PORTS
//   clock                    in   1   rising-edge clock
//   reset                    in   1   synchronous, active-high
//   op_if_id_write           in   1   1 = advance; 0 = stall (hold PC and IF/ID)
//   op_branch_taken_ex       in   1   branch in EX resolved taken this cycle
//   branch_target_ex         in   16  redirect target PC
//   restart                  in   1   leave HALT, resume at halted PC+1
//   imem_rdata               in   16  instruction word at imem_addr, same-cycle (async read)
//   imem_addr                out  16  = pc (combinational from pc register)
//   program_counter_pre_id   out  16  PC+1 of instruction in ID
//   instruction_register_id  out  16  instruction in ID (16'h0000 = bubble)
//   valid_id                 out  1   IF/ID holds a real instruction
//   flush_id_ex              out  1   = op_branch_taken_ex (comb.); ID/EX controller zeroes wrong-path ID op
//   halted                   out  1   FSM in HALT
//   stall_count              out  16  cycles with op_if_id_write=0 in RUN, saturating at 16'hFFFF
// BEHAVIOUR
//   Reset (sync, priority over all): pc<=RESET_PC; IF/ID outputs <=0; valid_id<=0; state<=RUN;
//     stall_count<=0. reset asserted mid-stall/mid-halt behaves identically.
//   FSM states RUN, HALT. halted = (state==HALT).
//   Per-edge priority in RUN: (1) branch, (2) stall, (3) normal advance.
//   Branch (op_branch_taken_ex=1): pc<=branch_target_ex; IF/ID<=bubble (pc_pre=0, ir=0, valid=0);
//     overrides simultaneous stall and simultaneous halt detection; stall_count not incremented.
//   Stall (op_if_id_write=0, no branch): pc, IF/ID, valid_id hold; stall_count+=1 (saturate).
//   Advance: ir<=imem_rdata; pc_pre<=pc+1; valid_id<=1; pc<=pc+1.
//     PC arithmetic is 16-bit modulo: 16'hFFFF+1 = 16'h0000, no flag.
//   HLT detect: on advance, if (imem_rdata & HALT_MASK)==HALT_PATTERN: HLT loaded into IF/ID
//     normally, pc<=pc+1, state<=HALT next edge.
//   In HALT: pc holds; IF/ID loads bubble on each edge where op_if_id_write=1 (HLT drains
//     downstream); holds if op_if_id_write=0; stall_count frozen.
//   HALT exits: op_branch_taken_ex=1 -> branch action, state<=RUN (HLT was wrong-path);
//     else restart=1 -> state<=RUN, pc unchanged (resumes at HLT address+1). branch wins over restart.
//   restart in RUN ignored.
//   Latency: instruction at imem_addr appears on instruction_register_id 1 cycle after its edge.
//   No combinational path from imem_rdata to any output.
// TESTING
//   Reset then 4 advancing cycles, imem[i]=16'h1000+i -> ir_id = 1000,1001,1002,1003; pc_pre = 1..4.
//   Hold op_if_id_write=0 3 cycles at pc=5 -> pc, ir_id, pc_pre unchanged; stall_count=3.
//   Branch taken target 16'h0040 with stall asserted same cycle -> next: pc=0x40, ir_id=0,
//     valid_id=0, flush_id_ex high during that cycle; following cycle ir_id=imem[0x40].
//   Fetch HLT at 0x0010 -> ir_id=HLT, halted=1 next cycle, pc=0x0011 held, bubbles after;
//     restart=1 -> fetch resumes at 0x0011.
//   In HALT, branch to 0x0008 with restart=1 same cycle -> RUN, pc=0x0008, IF/ID bubble.
//   pc=16'hFFFF advance -> pc=0, pc_pre_id=0; assert reset during HALT -> pc=RESET_PC, halted=0.

Source files
------------

// File: rtl/instruction_fetch.sv
// IF stage with IF/ID pipeline register: owns the PC, handles stall, branch redirect
// from EX, and a two-state RUN/HALT machine entered when an HLT word is fetched.
module instruction_fetch #(
  parameter logic [15:0] RESET_PC     = 16'h0000,
  parameter logic [15:0] HALT_PATTERN = 16'hC0F0,
  parameter logic [15:0] HALT_MASK    = 16'hC0F0
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        op_if_id_write,
  input  logic        op_branch_taken_ex,
  input  logic [15:0] branch_target_ex,
  input  logic        restart,
  input  logic [15:0] imem_rdata,
  output logic [15:0] imem_addr,
  output logic [15:0] program_counter_pre_id,
  output logic [15:0] instruction_register_id,
  output logic        valid_id,
  output logic        flush_id_ex,
  output logic        halted,
  output logic [15:0] stall_count
);

  typedef enum logic [0:0] {
    RUN  = 1'b0,
    HALT = 1'b1
  } state_t;

  state_t      state_r;
  logic [15:0] pc_r;
  logic [15:0] pc_pre_r;
  logic [15:0] ir_r;
  logic        valid_r;
  logic [15:0] stall_count_r;
  logic [15:0] pc_inc_s;

  function automatic logic is_halt(input logic [15:0] word);
    return (word & HALT_MASK) == HALT_PATTERN;
  endfunction

  // PC increment wraps modulo 2^16 with no carry out
  always_comb begin
    pc_inc_s = pc_r + 16'd1;
  end

  // PC, IF/ID register, stall counter and RUN/HALT state
  always_ff @(posedge clock) begin
    if (reset) begin
      pc_r          <= RESET_PC;
      pc_pre_r      <= 16'h0000;
      ir_r          <= 16'h0000;
      valid_r       <= 1'b0;
      stall_count_r <= 16'h0000;
      state_r       <= RUN;
    end else begin
      case (state_r)
        RUN: begin
          if (op_branch_taken_ex) begin
            pc_r     <= branch_target_ex;
            pc_pre_r <= 16'h0000;
            ir_r     <= 16'h0000;
            valid_r  <= 1'b0;
          end else if (!op_if_id_write) begin
            if (stall_count_r != 16'hFFFF) begin
              stall_count_r <= stall_count_r + 16'd1;
            end
          end else begin
            ir_r     <= imem_rdata;
            pc_pre_r <= pc_inc_s;
            valid_r  <= 1'b1;
            pc_r     <= pc_inc_s;
            if (is_halt(imem_rdata)) begin
              state_r <= HALT;
            end
          end
        end
        HALT: begin
          // A taken branch means the HLT was on the wrong path
          if (op_branch_taken_ex) begin
            pc_r     <= branch_target_ex;
            pc_pre_r <= 16'h0000;
            ir_r     <= 16'h0000;
            valid_r  <= 1'b0;
            state_r  <= RUN;
          end else begin
            if (op_if_id_write) begin
              pc_pre_r <= 16'h0000;
              ir_r     <= 16'h0000;
              valid_r  <= 1'b0;
            end
            if (restart) begin
              state_r <= RUN;
            end
          end
        end
        default: begin
          state_r <= RUN;
        end
      endcase
    end
  end

  assign imem_addr               = pc_r;
  assign program_counter_pre_id  = pc_pre_r;
  assign instruction_register_id = ir_r;
  assign valid_id                = valid_r;
  assign flush_id_ex             = op_branch_taken_ex;
  assign halted                  = (state_r == HALT);
  assign stall_count             = stall_count_r;

endmodule
